// File: rtl/drive_mode_sequencer.sv
// drive_mode_sequencer: power-button qualification, driving-mode arbitration and command muxing
// with a zero-command dead gap between modes.
module drive_mode_sequencer #(
    parameter int unsigned TICK_DIV         = 100000,
    parameter int unsigned POWER_HOLD_TICKS = 1000,
    parameter int unsigned GAP_TICKS        = 50,
    parameter int unsigned STABLE_TICKS     = 2
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       power_on_btn,
    input  logic       power_off_btn,
    input  logic [2:0] mode_sel,
    input  logic [3:0] man_cmd,
    input  logic [3:0] semi_cmd,
    input  logic [3:0] auto_cmd,
    output logic [2:0] mode_en,
    output logic [3:0] drive_cmd,
    output logic       power_led,
    output logic [2:0] mode_led,
    output logic [2:0] state_o
);
    localparam logic [2:0] OFF = 3'd0, ARMING = 3'd1, IDLE = 3'd2, RUN = 3'd3, GAP = 3'd4;
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(POWER_HOLD_TICKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int SW = $clog2(STABLE_TICKS + 1);

    logic [2:0] state, state_n, last_sel, last_n, active_mode, active_n;
    logic [TW-1:0] tick_cnt;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [SW-1:0] stable_cnt, stable_n;
    logic [3:0] cmd_q, cmd_n, sel_cmd;
    logic tick, valid;

    function automatic logic [3:0] sanitize(input logic [3:0] c);
        return {(c[3] & c[2]) ? 2'b00 : c[3:2], (c[1] & c[0]) ? 2'b00 : c[1:0]};
    endfunction

    assign tick  = tick_cnt == TW'(TICK_DIV - 1);
    assign valid = $onehot(mode_sel);

    always_comb begin
        state_n  = state;
        hold_n   = hold_cnt;
        gap_n    = gap_cnt;
        stable_n = stable_cnt;
        last_n   = last_sel;
        active_n = active_mode;
        if (state > GAP || (tick && power_off_btn)) begin
            state_n  = OFF;
            hold_n   = '0;
            gap_n    = '0;
            stable_n = '0;
            last_n   = '0;
            active_n = '0;
        end else if (tick) begin
            case (state)
                OFF: begin
                    state_n = power_on_btn ? ARMING : OFF;
                    hold_n  = power_on_btn ? HW'(1) : '0;
                end
                ARMING: begin
                    hold_n  = power_on_btn ? hold_cnt + HW'(1) : '0;
                    state_n = !power_on_btn ? OFF : (hold_n == HW'(POWER_HOLD_TICKS)) ? IDLE : ARMING;
                end
                IDLE: begin
                    last_n   = mode_sel;
                    stable_n = !valid ? '0 : (stable_cnt != '0 && mode_sel == last_sel) ? stable_cnt + SW'(1) : SW'(1);
                    if (stable_n == SW'(STABLE_TICKS)) begin
                        state_n  = RUN;
                        active_n = mode_sel;
                        stable_n = '0;
                    end
                end
                RUN: begin
                    // any mismatch counts, even if the mismatching pattern itself keeps changing
                    stable_n = (mode_sel != active_mode) ? stable_cnt + SW'(1) : '0;
                    if (stable_n == SW'(STABLE_TICKS)) begin
                        state_n  = GAP;
                        gap_n    = '0;
                        stable_n = '0;
                    end
                end
                default: begin
                    gap_n = gap_cnt + GW'(1);
                    if (gap_n == GW'(GAP_TICKS)) begin
                        gap_n    = '0;
                        state_n  = valid ? RUN : IDLE;
                        active_n = valid ? mode_sel : 3'b000;
                    end
                end
            endcase
        end
    end

    // Command is computed from the next mode so the first RUN cycle already carries the new engine.
    assign sel_cmd = active_n[0] ? man_cmd : active_n[1] ? semi_cmd : active_n[2] ? auto_cmd : 4'b0000;
    assign cmd_n   = (state_n == RUN) ? sanitize(sel_cmd) : 4'b0000;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            tick_cnt    <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            stable_cnt  <= '0;
            last_sel    <= '0;
            active_mode <= '0;
            cmd_q       <= '0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick ? '0 : tick_cnt + TW'(1);
            hold_cnt    <= hold_n;
            gap_cnt     <= gap_n;
            stable_cnt  <= stable_n;
            last_sel    <= last_n;
            active_mode <= active_n;
            cmd_q       <= cmd_n;
        end
    end

    assign mode_en   = (state == RUN) ? active_mode : 3'b000;
    assign mode_led  = mode_en;
    assign drive_cmd = cmd_q;
    assign power_led = state == IDLE || state == RUN || state == GAP;
    assign state_o   = state;
endmodule

// File: tb/tb_drive_mode_sequencer.sv
// tb_drive_mode_sequencer: directed plus randomized stimulus checked every cycle against a
// behavioural model of the power/mode rules.
module tb_drive_mode_sequencer;
    logic       sys_clk, rst_n, power_on_btn, power_off_btn;
    logic [2:0] mode_sel, mode_en, mode_led, state_o;
    logic [3:0] man_cmd, semi_cmd, auto_cmd, drive_cmd;
    logic       power_led;
    int checks = 0, errors = 0;

    // model: phase 0 off, 1 arming, 2 idle, 3 running, 4 gap
    int m_phase, m_hold, m_run, m_diff, m_gap, m_div;
    logic [2:0] m_last, m_active;
    logic [3:0] m_cmd;

    drive_mode_sequencer #(.TICK_DIV(4), .POWER_HOLD_TICKS(5), .GAP_TICKS(3), .STABLE_TICKS(2)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .power_on_btn(power_on_btn), .power_off_btn(power_off_btn),
        .mode_sel(mode_sel), .man_cmd(man_cmd), .semi_cmd(semi_cmd), .auto_cmd(auto_cmd),
        .mode_en(mode_en), .drive_cmd(drive_cmd), .power_led(power_led), .mode_led(mode_led),
        .state_o(state_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_hold = 0; m_run = 0; m_diff = 0; m_gap = 0; m_div = 0;
        m_last = 0; m_active = 0; m_cmd = 0;
    endtask

    function automatic logic [3:0] clean(input logic [3:0] c);
        logic [3:0] drop;
        drop = ((c[3] && c[2]) ? 4'b1100 : 4'b0000) | ((c[1] && c[0]) ? 4'b0011 : 4'b0000);
        return c & ~drop;
    endfunction

    task automatic model_step();
        bit tk, ok;
        tk = (m_div == 3);
        m_div = (m_div + 1) % 4;
        ok = (mode_sel == 3'b001 || mode_sel == 3'b010 || mode_sel == 3'b100);
        if (tk && power_off_btn) begin
            model_reset();
            m_div = 0;
        end else if (tk) begin
            if (m_phase == 0) begin
                if (power_on_btn) begin m_phase = 1; m_hold = 1; end
            end else if (m_phase == 1) begin
                if (!power_on_btn) begin m_phase = 0; m_hold = 0; end
                else if (++m_hold == 5) m_phase = 2;
            end else if (m_phase == 2) begin
                m_run = !ok ? 0 : (m_run > 0 && mode_sel == m_last) ? m_run + 1 : 1;
                m_last = mode_sel;
                if (m_run == 2) begin m_phase = 3; m_active = mode_sel; m_diff = 0; end
            end else if (m_phase == 3) begin
                m_diff = (mode_sel != m_active) ? m_diff + 1 : 0;
                if (m_diff == 2) begin m_phase = 4; m_gap = 0; end
            end else begin
                if (++m_gap == 3) begin
                    m_phase = ok ? 3 : 2;
                    m_active = ok ? mode_sel : 3'b000;
                    m_run = 0; m_diff = 0;
                end
            end
        end
        m_cmd = (m_phase != 3) ? 4'b0000 :
                clean(m_active == 3'b001 ? man_cmd : m_active == 3'b010 ? semi_cmd : auto_cmd);
    endtask

    task automatic check_outs(input string tag);
        logic [2:0] en;
        en = (m_phase == 3) ? m_active : 3'b000;
        chk({tag, ".state"}, 8'(state_o), 8'(m_phase));
        chk({tag, ".mode_en"}, 8'(mode_en), 8'(en));
        chk({tag, ".mode_led"}, 8'(mode_led), 8'(en));
        chk({tag, ".drive_cmd"}, 8'(drive_cmd), 8'(m_cmd));
        chk({tag, ".power_led"}, 8'(power_led), 8'(m_phase >= 2));
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        model_step();
        #1;
        check_outs("cyc");
    endtask

    initial begin
        sys_clk = 0; rst_n = 0;
        power_on_btn = 0; power_off_btn = 0; mode_sel = 0;
        man_cmd = 0; semi_cmd = 0; auto_cmd = 0;
        model_reset();
        #2;
        check_outs("reset");
        @(negedge sys_clk);
        rst_n = 1;
        // short hold aborts back to OFF without ever lighting power
        power_on_btn = 1;
        repeat (12) cyc();
        chk("arming_mid", 8'(state_o), 8'd1);
        power_on_btn = 0;
        repeat (8) cyc();
        chk("abort_off", 8'(state_o), 8'd0);
        // full hold powers up
        power_on_btn = 1;
        repeat (24) cyc();
        chk("idle", 8'(state_o), 8'd2);
        chk("idle_led", 8'(power_led), 8'd1);
        power_on_btn = 0;
        mode_sel = 3'b001; man_cmd = 4'b0001; semi_cmd = 4'b1111;
        repeat (8) cyc();
        chk("run_man", 8'(state_o), 8'd3);
        chk("run_man_en", 8'(mode_en), 8'd1);
        chk("run_man_cmd", 8'(drive_cmd), 8'd1);
        man_cmd = 4'b1101;
        cyc();
        chk("san_lr", 8'(drive_cmd), 8'b0001);
        man_cmd = 4'b0011;
        cyc();
        chk("san_fb", 8'(drive_cmd), 8'b0000);
        mode_sel = 3'b100; auto_cmd = 4'b0100;
        repeat (8) cyc();
        chk("gap", 8'(state_o), 8'd4);
        chk("gap_cmd", 8'(drive_cmd), 8'd0);
        repeat (12) cyc();
        chk("run_auto", 8'(state_o), 8'd3);
        chk("run_auto_en", 8'(mode_en), 8'd4);
        chk("run_auto_cmd", 8'(drive_cmd), 8'b0100);
        for (int i = 0; i < 1500; i++) begin
            man_cmd = 4'($urandom_range(15));
            semi_cmd = 4'($urandom_range(15));
            auto_cmd = 4'($urandom_range(15));
            if (i % 12 == 0)
                mode_sel = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'(1 << $urandom_range(2));
            power_on_btn = $urandom_range(9) != 0;
            power_off_btn = $urandom_range(150) == 0;
            cyc();
        end
        // both buttons while running means power-off
        power_on_btn = 0; power_off_btn = 1;
        repeat (4) cyc();
        power_off_btn = 0; power_on_btn = 1;
        repeat (24) cyc();
        power_on_btn = 0; mode_sel = 3'b010;
        repeat (8) cyc();
        chk("run_semi", 8'(state_o), 8'd3);
        power_on_btn = 1; power_off_btn = 1;
        repeat (4) cyc();
        chk("both_off", 8'(state_o), 8'd0);
        chk("both_off_cmd", 8'(drive_cmd), 8'd0);
        power_off_btn = 0;
        repeat (24) cyc();
        power_on_btn = 0; mode_sel = 3'b001;
        repeat (12) cyc();
        mode_sel = 3'b010;
        repeat (8) cyc();
        chk("gap2", 8'(state_o), 8'd4);
        // asynchronous reset in the middle of the gap
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_outs("async_rst");
        #2;
        rst_n = 1;
        repeat (40) cyc();
        chk("stay_off", 8'(state_o), 8'd0);
        power_on_btn = 1;
        repeat (24) cyc();
        chk("repower", 8'(state_o), 8'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/drive_mode_sequencer.md
Name: drive_mode_sequencer

Overview:
- Power and mode sequencer for the car top level.
- Qualifies the power-on/power-off buttons with tick-based hold timing and arbitrates the three driving-mode engines (manual, semi-auto, auto).
- Enables exactly one engine and muxes its 4-bit movement command onto the single command bus feeding the simulated device.
- Inserts a zero-command dead gap on every mode change, and owns the power and mode LEDs.

Parameters:
TICK_DIV, 100000, sys_clk cycles per sampling tick (1 kHz at 100 MHz)
POWER_HOLD_TICKS, 1000, consecutive ticks power_on_btn must be held to power up
GAP_TICKS, 50, ticks of zero command / no engine enabled between modes
STABLE_TICKS, 2, consecutive identical mode_sel samples required to accept a selection

Ports:
sys_clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
power_on_btn  input  1  power-on request, active high
power_off_btn  input  1  power-off request, active high
mode_sel  input  3  mode switches: 001 manual, 010 semi-auto, 100 auto; anything else invalid
man_cmd  input  4  manual engine command {left,right,back,forward}
semi_cmd  input  4  semi-auto engine command, same bit order
auto_cmd  input  4  auto engine command, same bit order
mode_en  output  3  one-hot enable to engines, same encoding as mode_sel
drive_cmd  output  4  command to device {left,right,back,forward}
power_led  output  1  high whenever state is not OFF/ARMING
mode_led  output  3  equals mode_en
state_o  output  3  current FSM state encoding

Behaviour:
- Reset (async on rst_n low): state OFF, tick counter 0, hold/gap/stable counters 0, active_mode 000; all outputs 0.
- Tick generator:
  - Counter runs 0..TICK_DIV-1.
  - tick is a one-cycle pulse on the cycle the counter equals TICK_DIV-1.
  - Button and mode_sel decisions are evaluated only on tick cycles.
- State encodings: OFF=0, ARMING=1, IDLE=2, RUN=3, GAP=4. Unused encodings go to OFF.
- Global priority:
  - power_off_btn high on a tick in any state other than OFF → OFF next cycle.
  - All counters clear, active_mode=000, outputs zero.
  - Both buttons high is treated as power-off.
- OFF: on tick with power_on_btn=1 → ARMING, hold_cnt=1.
- ARMING:
  - On tick with btn=1: hold_cnt++.
  - When hold_cnt==POWER_HOLD_TICKS → IDLE.
  - On tick with btn=0 → OFF, hold_cnt=0.
  - power_led stays 0 throughout ARMING.
- IDLE:
  - power_led=1, mode_en=0, drive_cmd=0.
  - stable_cnt counts consecutive ticks with valid, unchanged mode_sel; it resets to 1 on change and to 0 on invalid.
  - At STABLE_TICKS: latch active_mode=mode_sel → RUN.
- RUN:
  - mode_en=active_mode; drive_cmd registered from the selected engine's command (1-cycle latency from cmd input).
  - If mode_sel differs from active_mode (valid or invalid) for STABLE_TICKS consecutive ticks → GAP, gap_cnt=0.
  - On the GAP entry cycle, mode_en and drive_cmd go to 0.
- GAP:
  - mode_en=0, drive_cmd=0; gap_cnt++ per tick.
  - At GAP_TICKS: if mode_sel valid → active_mode=mode_sel, RUN; else active_mode=000, IDLE.
  - mode_sel changes during GAP do not restart the gap.
- Command sanitising (RUN only):
  - left&right both set → both bits 0.
  - forward&back both set → both bits 0.
  - The other pair passes unchanged.
- Reset mid-operation: immediate return to the reset state regardless of FSM state; no gap is emitted.
- Engine command inputs of non-selected modes are ignored entirely.

Test Plan:
(Bench params: TICK_DIV=4, POWER_HOLD_TICKS=5, GAP_TICKS=3, STABLE_TICKS=2.)
- Hold power_on_btn for 5 ticks → state 1 for 4 ticks, then state 2, power_led=1. Releasing after 3 ticks → state 0, power_led never asserted.
- In IDLE, mode_sel=001 for 2 ticks, man_cmd=4'b0001 → state 3, mode_en=001, mode_led=001, drive_cmd=0001 one clock after man_cmd applied. semi_cmd=1111 has no effect.
- In RUN manual, switch mode_sel to 100 → after 2 ticks state 4, drive_cmd=0000, mode_en=000 for 3 ticks. Then state 3, mode_en=100, drive_cmd follows auto_cmd.
- In RUN, man_cmd=4'b1101 → drive_cmd=4'b0001. man_cmd=4'b0011 → drive_cmd=4'b0000.
- In RUN, assert power_off_btn together with power_on_btn for one tick → state 0, all outputs 0 on the next cycle.
- Pulse rst_n low mid-GAP → all outputs 0 asynchronously. After release, FSM stays OFF until a fresh 5-tick power-on hold.
